fp_posit_mac_array: RTL and testbench

//  Multi-lane, parametrised successor of the single-lane FP16 x bit-serial-weight MAC.

---
 rtl/fp_posit_mac_array.sv | 201 ++++++++++++++++++++
 tb/tb_fp_posit_mac_array.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/fp_posit_mac_array.sv
// Multi-lane MAC: one FP16 activation broadcast to LANES lanes, each multiplied by its own
// MSB-first bit-serial signed weight and added into a fixed-point accumulator aligned to exp_min.
module fp_posit_mac_array #(
    parameter int unsigned LANES     = 4,
    parameter int unsigned ACC_WIDTH = 32,
    parameter int unsigned MAX_PREC  = 8,
    parameter int unsigned SATURATE  = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       set,
    input  logic [3:0]                 precision,
    input  logic [4:0]                 exp_min,
    input  logic [LANES*ACC_WIDTH-1:0] acc_init,
    input  logic                       valid,
    output logic                       ready,
    input  logic [15:0]                act,
    input  logic [LANES-1:0]           w,
    output logic [4:0]                 exp_out,
    output logic [LANES*ACC_WIDTH-1:0] acc_out,
    output logic [LANES-1:0]           ovf,
    output logic                       done
);

    // Aligned activation magnitude: 11-bit significand shifted left by up to 30.
    localparam int unsigned AW = 41;
    // Weight shift register is always 16 bits so a 4-bit precision can index it directly.
    localparam int unsigned WW = 16;
    localparam int unsigned PW = AW + 1 + WW;
    localparam int unsigned SW = ((ACC_WIDTH > PW) ? ACC_WIDTH : PW) + 1;

    localparam logic [3:0]           PREC_MAX = 4'(MAX_PREC);
    localparam logic [ACC_WIDTH-1:0] ACC_MAX  = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN  = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        ADD   = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic [3:0]                 cnt_q, cnt_d;
    logic [3:0]                 prec_q, prec_d;
    logic [15:0]                act_q, act_d;
    logic [WW-1:0]              wsr_q [LANES];
    logic [WW-1:0]              wsr_d [LANES];
    logic [4:0]                 exp_d;
    logic [LANES*ACC_WIDTH-1:0] acc_d;
    logic [LANES-1:0]           ovf_d;
    logic                       done_d;
    logic                       ready_d;
    logic [3:0]                 prec_clamped;

    logic [10:0]                sig;
    logic [4:0]                 e_eff;
    logic [AW-1:0]              a_mag;
    logic signed [AW:0]         a_sgn;
    logic                       act_inf;
    logic [ACC_WIDTH-1:0]       add_acc [LANES];
    logic [LANES-1:0]           add_ovf;

    always_comb begin
        if (precision < 4'd2) begin
            prec_clamped = 4'd2;
        end else if (precision > PREC_MAX) begin
            prec_clamped = PREC_MAX;
        end else begin
            prec_clamped = precision;
        end
    end

    // Activation decode and alignment to the latched exp_min (right shift truncates).
    always_comb begin
        sig     = {|act_q[14:10], act_q[9:0]};
        e_eff   = (act_q[14:10] == 5'd0) ? 5'd1 : act_q[14:10];
        act_inf = &act_q[14:10];
        if (e_eff >= exp_out) begin
            a_mag = AW'(sig) << (e_eff - exp_out);
        end else begin
            a_mag = AW'(sig) >> (exp_out - e_eff);
        end
        a_sgn = act_q[15] ? -$signed({1'b0, a_mag}) : $signed({1'b0, a_mag});
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic signed [WW-1:0]        wv;
        logic signed [ACC_WIDTH-1:0] acc_cur;
        logic signed [SW-1:0]        prod;
        logic signed [SW-1:0]        sum;
        logic                        fits;
        logic [ACC_WIDTH-1:0]        res;
        logic                        res_ovf;

        // Exact product and full-width sum; range check against the accumulator width.
        always_comb begin
            wv = '0;
            for (int j = 0; j < int'(WW); j++) begin
                wv[j] = (j < int'(prec_q)) ? wsr_q[i][j] : wsr_q[i][prec_q - 4'd1];
            end
            acc_cur = $signed(acc_out[i*ACC_WIDTH +: ACC_WIDTH]);
            prod    = SW'(a_sgn) * SW'(wv);
            sum     = SW'(acc_cur) + prod;
            fits    = (sum[SW-1:ACC_WIDTH-1] == '0) || (sum[SW-1:ACC_WIDTH-1] == '1);
            res     = sum[ACC_WIDTH-1:0];
            res_ovf = ~fits;
            if (!fits && (SATURATE != 0)) begin
                res = sum[SW-1] ? ACC_MIN : ACC_MAX;
            end
            if (act_inf && (wv != '0)) begin
                res     = (act_q[15] ^ wv[WW-1]) ? ACC_MIN : ACC_MAX;
                res_ovf = 1'b1;
            end
        end

        assign add_acc[i] = res;
        assign add_ovf[i] = res_ovf;
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prec_d  = prec_q;
        act_d   = act_q;
        wsr_d   = wsr_q;
        exp_d   = exp_out;
        acc_d   = acc_out;
        ovf_d   = ovf;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (set) begin
                    prec_d = prec_clamped;
                    exp_d  = exp_min;
                    acc_d  = acc_init;
                    ovf_d  = '0;
                end else if (valid) begin
                    act_d = act;
                    for (int i = 0; i < int'(LANES); i++) begin
                        wsr_d[i] = WW'(w[i]);
                    end
                    cnt_d   = prec_q - 4'd1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (valid) begin
                    for (int i = 0; i < int'(LANES); i++) begin
                        wsr_d[i] = {wsr_q[i][WW-2:0], w[i]};
                    end
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = ADD;
                    end
                end
            end
            ADD: begin
                for (int i = 0; i < int'(LANES); i++) begin
                    acc_d[i*ACC_WIDTH +: ACC_WIDTH] = add_acc[i];
                end
                ovf_d   = ovf | add_ovf;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            prec_q  <= PREC_MAX;
            act_q   <= '0;
            for (int i = 0; i < int'(LANES); i++) begin
                wsr_q[i] <= '0;
            end
            exp_out <= '0;
            acc_out <= '0;
            ovf     <= '0;
            done    <= 1'b0;
            ready   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prec_q  <= prec_d;
            act_q   <= act_d;
            for (int i = 0; i < int'(LANES); i++) begin
                wsr_q[i] <= wsr_d[i];
            end
            exp_out <= exp_d;
            acc_out <= acc_d;
            ovf     <= ovf_d;
            done    <= done_d;
            ready   <= ready_d;
        end
    end

endmodule

// File: tb/tb_fp_posit_mac_array.sv
// Directed + random bench for fp_posit_mac_array; expected accumulators come from a
// behavioural model and are queued at op start, then compared when done pulses.
module tb_fp_posit_mac_array;

    logic         clk = 1'b0;
    logic         rst;
    logic         set;
    logic [3:0]   precision;
    logic [4:0]   exp_min;
    logic [127:0] acc_init;
    logic         valid;
    logic         ready;
    logic [15:0]  act;
    logic [3:0]   w;
    logic [4:0]   exp_out;
    logic [127:0] acc_out;
    logic [3:0]   ovf;
    logic         done;

    fp_posit_mac_array #(
        .LANES(4), .ACC_WIDTH(32), .MAX_PREC(8), .SATURATE(1)
    ) dut (
        .clk(clk), .rst(rst), .set(set), .precision(precision), .exp_min(exp_min),
        .acc_init(acc_init), .valid(valid), .ready(ready), .act(act), .w(w),
        .exp_out(exp_out), .acc_out(acc_out), .ovf(ovf), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] acc;
        logic [3:0]   ovf;
    } exp_t;

    exp_t         sbq [$];
    int           n_checks = 0;
    int           n_errors = 0;
    int           sh_prec;
    int           sh_emin;
    logic [127:0] sh_acc;
    logic [3:0]   sh_ovf;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Returns {ovf_set, new_acc} for one lane.
    function automatic logic [32:0] model(input logic [15:0] a, input logic [7:0] wb,
                                          input int prec, input int emin, input logic [31:0] acc);
        longint wv, sig, am, sum, maxv, minv;
        int e, ee;
        maxv = (longint'(1) << 31) - 1;
        minv = -(longint'(1) << 31);
        wv = 0;
        for (int j = 0; j < prec; j++)
            if (wb[j]) wv += (j == prec - 1) ? -(longint'(1) << j) : (longint'(1) << j);
        if (wv == 0) return {1'b0, acc};
        e = int'(a[14:10]);
        if (e == 31) return {1'b1, ((a[15] == 1'b1) != (wv < 0)) ? 32'h8000_0000 : 32'h7FFF_FFFF};
        sig = longint'(a[9:0]) + ((e != 0) ? 1024 : 0);
        ee  = (e == 0) ? 1 : e;
        am  = (ee >= emin) ? (sig << (ee - emin)) : (sig >> (emin - ee));
        if (a[15]) am = -am;
        sum = longint'($signed(acc)) + am * wv;
        if (sum > maxv) return {1'b1, 32'h7FFF_FFFF};
        if (sum < minv) return {1'b1, 32'h8000_0000};
        return {1'b0, sum[31:0]};
    endfunction

    // Scoreboard consumer: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst && done) begin
            chk("sb_has_entry", 128'(sbq.size() != 0), 128'd1);
            if (sbq.size() != 0) begin
                exp_t e;
                e = sbq.pop_front();
                chk("sb_acc", acc_out, e.acc);
                chk("sb_ovf", 128'(ovf), 128'(e.ovf));
            end
        end
    end

    task automatic do_set(input logic [3:0] p, input logic [4:0] em, input logic [127:0] init);
        set = 1'b1; precision = p; exp_min = em; acc_init = init;
        valid = 1'b1; w = 4'hF; act = 16'h3C00;
        @(negedge clk);
        set = 1'b0; valid = 1'b0;
        sh_prec = (p < 2) ? 2 : ((p > 8) ? 8 : int'(p));
        sh_emin = int'(em); sh_acc = init; sh_ovf = '0;
        chk("set_exp", 128'(exp_out), 128'(em));
        chk("set_acc", acc_out, init);
        chk("set_ovf", 128'(ovf), 128'd0);
        chk("set_ready", 128'(ready), 128'd1);
    endtask

    // Entered and left on a negedge; leaves in the done cycle so a new op can start.
    task automatic run_op(input logic [15:0] a, input logic [31:0] wpk,
                          input int stall_after, input int stall_n);
        exp_t e;
        logic [32:0] r;
        for (int i = 0; i < 4; i++) begin
            r = model(a, wpk[i*8 +: 8], sh_prec, sh_emin, sh_acc[i*32 +: 32]);
            sh_acc[i*32 +: 32] = r[31:0];
            sh_ovf[i] = sh_ovf[i] | r[32];
        end
        e.acc = sh_acc; e.ovf = sh_ovf;
        sbq.push_back(e);
        chk("op_ready_start", 128'(ready), 128'd1);
        for (int b = sh_prec - 1; b >= 0; b--) begin
            if (b != sh_prec - 1) chk("op_ready_busy", 128'(ready), 128'd0);
            valid = 1'b1;
            act = (b == sh_prec - 1) ? a : 16'hFFFF;
            for (int i = 0; i < 4; i++) w[i] = wpk[i*8 + b];
            @(negedge clk);
            if (stall_n > 0 && (sh_prec - b) == stall_after) begin
                valid = 1'b0; w = 4'($urandom);
                for (int k = 0; k < stall_n; k++) begin
                    chk("stall_ready", 128'(ready), 128'd0);
                    chk("stall_done", 128'(done), 128'd0);
                    @(negedge clk);
                end
            end
        end
        valid = 1'b0;
        chk("add_done_low", 128'(done), 128'd0);
        chk("add_ready_low", 128'(ready), 128'd0);
        @(negedge clk);
        chk("done_pulse", 128'(done), 128'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; set = 1'b0; valid = 1'b0; precision = '0; exp_min = '0;
        acc_init = '0; act = '0; w = '0;
        repeat (3) @(negedge clk);
        chk("rst_acc", acc_out, 128'd0);
        chk("rst_ovf", 128'(ovf), 128'd0);
        chk("rst_done", 128'(done), 128'd0);
        chk("rst_ready", 128'(ready), 128'd1);
        chk("rst_exp", 128'(exp_out), 128'd0);
        rst = 1'b1;
        sh_prec = 8; sh_emin = 0; sh_acc = '0; sh_ovf = '0;
        @(negedge clk);

        // Case 1: 1.0 x 3 at exp_min=15.
        do_set(4'd4, 5'd15, '0);
        run_op(16'h3C00, 32'h0000_0003, 0, 0);
        chk("t1_acc0", 128'(acc_out[31:0]), 128'h0000_0C00);
        // Case 2: negative weight, then negative activation.
        run_op(16'h3C00, 32'h0000_0F00, 0, 0);
        chk("t2_acc1", 128'(acc_out[63:32]), 128'hFFFF_FC00);
        @(negedge clk);
        run_op(16'hBC00, 32'h0005_0000, 0, 0);
        chk("t2_acc2", 128'(acc_out[95:64]), 128'hFFFF_EC00);
        chk("t2_acc0_kept", 128'(acc_out[31:0]), 128'h0000_0C00);
        // Case 3: right-shift alignment, back-to-back ops.
        do_set(4'd4, 5'd20, '0);
        run_op(16'h3C00, 32'h0000_0002, 0, 0);
        chk("t3_acc0", 128'(acc_out[31:0]), 128'h0000_0040);
        run_op(16'h3C00, 32'h0000_0002, 0, 0);
        chk("t3_acc0_b2b", 128'(acc_out[31:0]), 128'h0000_0080);
        // Case 4: stall 3 cycles between bits 2 and 3.
        do_set(4'd4, 5'd15, '0);
        run_op(16'h3C00, 32'h0000_0003, 2, 3);
        chk("t4_acc0", 128'(acc_out[31:0]), 128'h0000_0C00);
        // Case 5: saturation, then set clears ovf.
        do_set(4'd4, 5'd0, {96'd0, 32'h7FFF_FFF0});
        run_op(16'h7800, 32'h0000_0001, 0, 0);
        chk("t5_acc0", 128'(acc_out[31:0]), 128'h7FFF_FFFF);
        chk("t5_ovf0", 128'(ovf[0]), 128'd1);
        // Case 6: infinity with zero and nonzero weights.
        do_set(4'd4, 5'd0, {96'd0, 32'h7FFF_FFF0});
        run_op(16'h7C00, 32'h0000_0100, 0, 0);
        chk("t6_acc0", 128'(acc_out[31:0]), 128'h7FFF_FFF0);
        chk("t6_acc1", 128'(acc_out[63:32]), 128'h7FFF_FFFF);
        chk("t6_ovf", 128'(ovf), 128'h2);
        run_op(16'hFC00, 32'h0300_0000, 0, 0);
        // Precision clamps high (15 -> 8) and low (1 -> 2), random operands.
        do_set(4'd15, 5'($urandom_range(0, 31)), {$urandom, $urandom, $urandom, $urandom});
        for (int k = 0; k < 6; k++) begin
            run_op(16'($urandom), $urandom, (k == 2) ? 5 : 0, (k == 2) ? 2 : 0);
            @(negedge clk);
        end
        do_set(4'd1, 5'd10, {$urandom, $urandom, $urandom, $urandom});
        for (int k = 0; k < 3; k++) run_op(16'($urandom), $urandom, 0, 0);
        // Reset in the middle of SHIFT.
        @(negedge clk);
        do_set(4'd4, 5'd15, {4{32'h1234_5678}});
        valid = 1'b1; act = 16'h3C00; w = 4'hF;
        repeat (2) @(negedge clk);
        rst = 1'b0; valid = 1'b0;
        @(negedge clk);
        chk("abort_acc", acc_out, 128'd0);
        chk("abort_ovf", 128'(ovf), 128'd0);
        chk("abort_done", 128'(done), 128'd0);
        chk("abort_ready", 128'(ready), 128'd1);
        chk("abort_exp", 128'(exp_out), 128'd0);
        rst = 1'b1;
        sh_prec = 8; sh_emin = 0; sh_acc = '0; sh_ovf = '0;
        @(negedge clk);
        run_op(16'h0001, 32'h0503_7F81, 0, 0);
        for (int k = 0; k < 20 && sbq.size() != 0; k++) @(negedge clk);
        chk("sb_drained", 128'(sbq.size()), 128'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
